// File: rtl/packetfilt_dispatch_pkg.sv
// Shared definitions for the packet-filter dispatcher.
// Holds the lock-FSM state encoding, the default widths and the
// round-robin search helper that both arbiters use.
package packetfilt_dispatch_pkg;

    localparam int unsigned DEF_N_FILT = 4;
    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_PLEN_W = 10;
    localparam int unsigned DROP_W     = 16;
    localparam int unsigned MAX_FILT   = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of ready_vec, searching from last+1 and wrapping modulo n.
    function automatic rr_pick_t next_rr(input logic [MAX_FILT-1:0] ready_vec,
                                         input logic [IDX_W-1:0]    last,
                                         input int unsigned         n);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_FILT; k++) begin
            cand = (32'(last) + k) % n;
            if (k <= n && !pick.found && ready_vec[cand[IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/packetfilt_dispatch_rr_lock_arb.sv
// Lock-on round-robin arbiter.
// Grants one requester whose req bit is high, holds the grant until
// release_req, then resumes searching after the last granted index.
// Ports: clk, resetn (async active-low), req[N] per-requester ready,
//        release_req end-of-packet pulse, locked (registered grant
//        valid), sel (granted index, stable while locked and after).
module rr_lock_arb
    import packetfilt_dispatch_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             release_req,
    output logic             locked,
    output logic [SEL_W-1:0] sel
);

    lock_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    rr_pick_t         pick;

    // Next-state: search in IDLE, hold in LOCKED until the release pulse.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        pick    = next_rr(MAX_FILT'(req), IDX_W'(last_q), N);
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    sel_d   = SEL_W'(pick.idx);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Release regardless of the requester's ready level.
                if (release_req) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, select and round-robin pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);
    assign sel    = sel_q;

endmodule

// File: rtl/packetfilt_dispatch.sv
// Round-robin dispatcher sharing one snooper and one forwarder among
// N_FILT packet filters. Each side locks onto a ready filter for one
// packet and steers strobes/data to it; sides are independent.
// Ports: snooper_* / forwarder_* upstream interfaces, ready_for_* lock
// status, filt_* flattened per-filter vectors (filter i = slice i),
// drop_count saturating count of snooper strobes seen while unlocked.
module packetfilt_dispatch
    import packetfilt_dispatch_pkg::*;
#(
    parameter int unsigned N_FILT               = DEF_N_FILT,
    parameter int unsigned SNOOP_FWD_ADDR_WIDTH = DEF_ADDR_W,
    parameter int unsigned DATA_WIDTH           = DEF_DATA_W,
    parameter int unsigned PLEN_WIDTH           = DEF_PLEN_W
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]   snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0]             snooper_wr_data,
    input  logic                              snooper_wr_en,
    input  logic                              snooper_done,
    output logic                              ready_for_snooper,
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]   forwarder_rd_addr,
    input  logic                              forwarder_rd_en,
    input  logic                              forwarder_done,
    output logic [DATA_WIDTH-1:0]             forwarder_rd_data,
    output logic                              ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]             len_to_forwarder,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0]   filt_wr_addr,
    output logic [DATA_WIDTH-1:0]             filt_wr_data,
    output logic [N_FILT-1:0]                 filt_wr_en,
    output logic [N_FILT-1:0]                 filt_snooper_done,
    input  logic [N_FILT-1:0]                 filt_ready_for_snooper,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0]   filt_rd_addr,
    output logic [N_FILT-1:0]                 filt_rd_en,
    output logic [N_FILT-1:0]                 filt_forwarder_done,
    input  logic [N_FILT*DATA_WIDTH-1:0]      filt_rd_data,
    input  logic [N_FILT-1:0]                 filt_ready_for_forwarder,
    input  logic [N_FILT*PLEN_WIDTH-1:0]      filt_len,
    output logic [DROP_W-1:0]                 drop_count
);

    localparam int unsigned SEL_W = $clog2(N_FILT);

    logic             snp_locked, fwd_locked;
    logic [SEL_W-1:0] snp_sel, fwd_sel;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic             snp_orphan;

    rr_lock_arb #(.N(N_FILT)) u_snp_arb (
        .clk         (axi_aclk),
        .resetn      (axi_aresetn),
        .req         (filt_ready_for_snooper),
        .release_req (snooper_done),
        .locked      (snp_locked),
        .sel         (snp_sel)
    );

    rr_lock_arb #(.N(N_FILT)) u_fwd_arb (
        .clk         (axi_aclk),
        .resetn      (axi_aresetn),
        .req         (filt_ready_for_forwarder),
        .release_req (forwarder_done),
        .locked      (fwd_locked),
        .sel         (fwd_sel)
    );

    assign ready_for_snooper   = snp_locked;
    assign ready_for_forwarder = fwd_locked;
    assign filt_wr_addr        = snooper_wr_addr;
    assign filt_wr_data        = snooper_wr_data;
    assign filt_rd_addr        = forwarder_rd_addr;

    // One-hot strobe steering and return-path muxes keyed by each side's sel.
    always_comb begin
        filt_wr_en          = '0;
        filt_snooper_done   = '0;
        filt_rd_en          = '0;
        filt_forwarder_done = '0;
        forwarder_rd_data   = '0;
        len_to_forwarder    = '0;
        for (int unsigned i = 0; i < N_FILT; i++) begin
            if (SEL_W'(i) == snp_sel) begin
                filt_wr_en[i]        = snp_locked & snooper_wr_en;
                filt_snooper_done[i] = snp_locked & snooper_done;
            end
            if (SEL_W'(i) == fwd_sel) begin
                filt_rd_en[i]          = fwd_locked & forwarder_rd_en;
                filt_forwarder_done[i] = fwd_locked & forwarder_done;
                // sel holds after done, so trailing reads still see this slice.
                forwarder_rd_data = filt_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                len_to_forwarder  = filt_len[i*PLEN_WIDTH +: PLEN_WIDTH];
            end
        end
    end

    // Saturating count of snooper strobes with no filter locked.
    always_comb begin
        snp_orphan   = !snp_locked && (snooper_wr_en || snooper_done);
        drop_count_d = drop_count_q;
        if (snp_orphan && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_packetfilt_dispatch.sv
// Directed self-checking bench for packetfilt_dispatch (N_FILT = 4).
module tb_packetfilt_dispatch;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 10;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   snooper_wr_addr;
    logic [DW-1:0]   snooper_wr_data;
    logic            snooper_wr_en;
    logic            snooper_done;
    logic            ready_for_snooper;
    logic [AW-1:0]   forwarder_rd_addr;
    logic            forwarder_rd_en;
    logic            forwarder_done;
    logic [DW-1:0]   forwarder_rd_data;
    logic            ready_for_forwarder;
    logic [LW-1:0]   len_to_forwarder;
    logic [AW-1:0]   filt_wr_addr;
    logic [DW-1:0]   filt_wr_data;
    logic [N-1:0]    filt_wr_en;
    logic [N-1:0]    filt_snooper_done;
    logic [N-1:0]    filt_ready_for_snooper;
    logic [AW-1:0]   filt_rd_addr;
    logic [N-1:0]    filt_rd_en;
    logic [N-1:0]    filt_forwarder_done;
    logic [N*DW-1:0] filt_rd_data;
    logic [N-1:0]    filt_ready_for_forwarder;
    logic [N*LW-1:0] filt_len;
    logic [15:0]     drop_count;

    int checks;
    int failures;

    packetfilt_dispatch #(
        .N_FILT(N), .SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(LW)
    ) dut (
        .axi_aclk                 (clk),
        .axi_aresetn              (rst_n),
        .snooper_wr_addr          (snooper_wr_addr),
        .snooper_wr_data          (snooper_wr_data),
        .snooper_wr_en            (snooper_wr_en),
        .snooper_done             (snooper_done),
        .ready_for_snooper        (ready_for_snooper),
        .forwarder_rd_addr        (forwarder_rd_addr),
        .forwarder_rd_en          (forwarder_rd_en),
        .forwarder_done           (forwarder_done),
        .forwarder_rd_data        (forwarder_rd_data),
        .ready_for_forwarder      (ready_for_forwarder),
        .len_to_forwarder         (len_to_forwarder),
        .filt_wr_addr             (filt_wr_addr),
        .filt_wr_data             (filt_wr_data),
        .filt_wr_en               (filt_wr_en),
        .filt_snooper_done        (filt_snooper_done),
        .filt_ready_for_snooper   (filt_ready_for_snooper),
        .filt_rd_addr             (filt_rd_addr),
        .filt_rd_en               (filt_rd_en),
        .filt_forwarder_done      (filt_forwarder_done),
        .filt_rd_data             (filt_rd_data),
        .filt_ready_for_forwarder (filt_ready_for_forwarder),
        .filt_len                 (filt_len),
        .drop_count               (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-filter read data and length (same constants driven below).
    function automatic logic [DW-1:0] exp_rd(input int i);
        return 64'hD000_0000_0000_0000 + 64'(i) * 64'h0101;
    endfunction

    function automatic logic [LW-1:0] exp_len(input int i);
        return (i == 2) ? 10'd60 : 10'(11 * (i + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        snooper_wr_addr          = '0;
        snooper_wr_data          = '0;
        snooper_wr_en            = 1'b0;
        snooper_done             = 1'b0;
        forwarder_rd_addr        = '0;
        forwarder_rd_en          = 1'b0;
        forwarder_done           = 1'b0;
        filt_ready_for_snooper   = '0;
        filt_ready_for_forwarder = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (ready_for_snooper !== 1'b0 || ready_for_forwarder !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=00", ready_for_snooper, ready_for_forwarder);
        end
        checks++;
        if (drop_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_drop got=%h exp=0000", drop_count);
        end
        snooper_wr_en = 1'b1; forwarder_rd_en = 1'b1;
        #1;
        checks++;
        if (filt_wr_en !== 4'b0 || filt_rd_en !== 4'b0) begin
            failures++;
            $display("FAIL reset_onehot got=%b/%b exp=0000/0000", filt_wr_en, filt_rd_en);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_packet();
        filt_ready_for_snooper = 4'b0001;
        #1;
        checks++;
        if (ready_for_snooper !== 1'b0) begin
            failures++;
            $display("FAIL sp_pre_grant got=%b exp=0", ready_for_snooper);
        end
        tick();
        checks++;
        if (ready_for_snooper !== 1'b1) begin
            failures++;
            $display("FAIL sp_grant got=%b exp=1", ready_for_snooper);
        end
        // Drop ready without done: lock must hold.
        filt_ready_for_snooper = 4'b0000;
        snooper_wr_en = 1'b1; snooper_wr_addr = 9'h105; snooper_wr_data = 64'hCAFE_F00D_1234_5678;
        #1;
        checks++;
        if (filt_wr_en !== 4'b0001 || filt_wr_addr !== 9'h105 || filt_wr_data !== 64'hCAFE_F00D_1234_5678) begin
            failures++;
            $display("FAIL sp_write got=%b/%h/%h exp=0001/105/cafef00d12345678", filt_wr_en, filt_wr_addr, filt_wr_data);
        end
        tick();
        snooper_wr_en = 1'b0;
        tick();
        checks++;
        if (ready_for_snooper !== 1'b1) begin
            failures++;
            $display("FAIL sp_hold got=%b exp=1", ready_for_snooper);
        end
        snooper_wr_en = 1'b1; snooper_done = 1'b1;
        #1;
        checks++;
        if (filt_snooper_done !== 4'b0001 || filt_wr_en !== 4'b0001) begin
            failures++;
            $display("FAIL sp_done got=%b/%b exp=0001/0001", filt_snooper_done, filt_wr_en);
        end
        tick();
        snooper_wr_en = 1'b0; snooper_done = 1'b0;
        #1;
        checks++;
        if (ready_for_snooper !== 1'b0 || drop_count !== 16'h0) begin
            failures++;
            $display("FAIL sp_release got=%b/%h exp=0/0000", ready_for_snooper, drop_count);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        apply_reset();
        filt_ready_for_snooper = 4'b1111;
        tick();
        for (int p = 0; p < 5; p++) begin
            exp = 4'b0001 << (p % 4);
            checks++;
            if (ready_for_snooper !== 1'b1) begin
                failures++;
                $display("FAIL rr_ready_%0d got=%b exp=1", p, ready_for_snooper);
            end
            snooper_wr_en = 1'b1; snooper_done = 1'b1;
            #1;
            checks++;
            if (filt_wr_en !== exp || filt_snooper_done !== exp) begin
                failures++;
                $display("FAIL rr_grant_%0d got=%b/%b exp=%b", p, filt_wr_en, filt_snooper_done, exp);
            end
            if (p == 4) filt_ready_for_snooper = 4'b0101;
            tick();
            snooper_wr_en = 1'b0; snooper_done = 1'b0;
            #1;
            checks++;
            if (ready_for_snooper !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap_%0d got=%b exp=0", p, ready_for_snooper);
            end
            tick();
        end
        // Last grant was 0 with filters 0 and 2 ready: search from 1 picks 2.
        snooper_wr_en = 1'b1;
        #1;
        checks++;
        if (filt_wr_en !== 4'b0100) begin
            failures++;
            $display("FAIL rr_skip got=%b exp=0100", filt_wr_en);
        end
        snooper_done = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_forwarder();
        apply_reset();
        filt_ready_for_forwarder = 4'b0100;
        tick();
        checks++;
        if (ready_for_forwarder !== 1'b1 || len_to_forwarder !== 10'd60 || forwarder_rd_data !== exp_rd(2)) begin
            failures++;
            $display("FAIL fwd_lock got=%b/%0d/%h exp=1/60/%h", ready_for_forwarder, len_to_forwarder, forwarder_rd_data, exp_rd(2));
        end
        forwarder_rd_en = 1'b1; forwarder_rd_addr = 9'h007;
        #1;
        checks++;
        if (filt_rd_en !== 4'b0100 || filt_rd_addr !== 9'h007) begin
            failures++;
            $display("FAIL fwd_read got=%b/%h exp=0100/007", filt_rd_en, filt_rd_addr);
        end
        forwarder_done = 1'b1;
        #1;
        checks++;
        if (filt_forwarder_done !== 4'b0100 || filt_rd_en !== 4'b0100) begin
            failures++;
            $display("FAIL fwd_done got=%b/%b exp=0100/0100", filt_forwarder_done, filt_rd_en);
        end
        filt_ready_for_forwarder = 4'b0000;
        tick();
        forwarder_done = 1'b0;
        #1;
        checks++;
        if (ready_for_forwarder !== 1'b0 || forwarder_rd_data !== exp_rd(2) || len_to_forwarder !== 10'd60 || filt_rd_en !== 4'b0) begin
            failures++;
            $display("FAIL fwd_trailing got=%b/%h/%0d/%b exp=0/%h/60/0000", ready_for_forwarder, forwarder_rd_data, len_to_forwarder, filt_rd_en, exp_rd(2));
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_orphan();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            if (p == 2) snooper_done = 1'b1;
            else snooper_wr_en = 1'b1;
            #1;
            checks++;
            if (filt_wr_en !== 4'b0 || filt_snooper_done !== 4'b0) begin
                failures++;
                $display("FAIL orphan_strobe_%0d got=%b/%b exp=0000/0000", p, filt_wr_en, filt_snooper_done);
            end
            tick();
            snooper_wr_en = 1'b0; snooper_done = 1'b0;
            tick();
        end
        forwarder_rd_en = 1'b1; forwarder_done = 1'b1;
        tick();
        forwarder_rd_en = 1'b0; forwarder_done = 1'b0;
        checks++;
        if (drop_count !== 16'd3) begin
            failures++;
            $display("FAIL orphan_count got=%0d exp=3", drop_count);
        end
        snooper_wr_en = 1'b1;
        repeat (65531) tick();
        checks++;
        if (drop_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL orphan_near_sat got=%h exp=fffe", drop_count);
        end
        tick();
        checks++;
        if (drop_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL orphan_sat got=%h exp=ffff", drop_count);
        end
        repeat (5) tick();
        checks++;
        if (drop_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL orphan_hold got=%h exp=ffff", drop_count);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        filt_ready_for_snooper = 4'b0001;
        tick();
        snooper_wr_en = 1'b1; snooper_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_for_snooper !== 1'b0 || filt_wr_en !== 4'b0 || filt_snooper_done !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%b exp=0/0000/0000", ready_for_snooper, filt_wr_en, filt_snooper_done);
        end
        snooper_wr_en = 1'b0; snooper_done = 1'b0;
        filt_ready_for_snooper = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready_for_snooper !== 1'b1) begin
            failures++;
            $display("FAIL mid_regrant got=%b exp=1", ready_for_snooper);
        end
        snooper_wr_en = 1'b1;
        #1;
        checks++;
        if (filt_wr_en !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first_grant got=%b exp=0001", filt_wr_en);
        end
        snooper_done = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_independence();
        apply_reset();
        filt_ready_for_snooper   = 4'b0010;
        filt_ready_for_forwarder = 4'b1000;
        tick();
        snooper_wr_en = 1'b1; forwarder_rd_en = 1'b1;
        #1;
        checks++;
        if (filt_wr_en !== 4'b0010 || filt_rd_en !== 4'b1000) begin
            failures++;
            $display("FAIL ind_steer got=%b/%b exp=0010/1000", filt_wr_en, filt_rd_en);
        end
        checks++;
        if (forwarder_rd_data !== exp_rd(3) || len_to_forwarder !== exp_len(3)) begin
            failures++;
            $display("FAIL ind_mux got=%h/%0d exp=%h/%0d", forwarder_rd_data, len_to_forwarder, exp_rd(3), exp_len(3));
        end
        snooper_done = 1'b1;
        #1;
        checks++;
        if (filt_snooper_done !== 4'b0010 || filt_forwarder_done !== 4'b0000) begin
            failures++;
            $display("FAIL ind_done got=%b/%b exp=0010/0000", filt_snooper_done, filt_forwarder_done);
        end
        tick();
        snooper_wr_en = 1'b0; snooper_done = 1'b0;
        #1;
        checks++;
        if (ready_for_snooper !== 1'b0 || ready_for_forwarder !== 1'b1 || filt_rd_en !== 4'b1000 || drop_count !== 16'h0) begin
            failures++;
            $display("FAIL ind_after got=%b/%b/%b/%h exp=0/1/1000/0000", ready_for_snooper, ready_for_forwarder, filt_rd_en, drop_count);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < int'(N); i++) begin
            filt_rd_data[i*DW +: DW] = exp_rd(i);
            filt_len[i*LW +: LW]     = exp_len(i);
        end
        rst_n = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_forwarder();
        test_orphan();
        test_reset_mid_packet();
        test_independence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
